// File: rtl/block_pattern_gen.sv
// Lane-enable pattern generator for the falling-block display: table mode maps the
// note address to one lane, random mode draws from a Galois LFSR. Option: BLOCK_PATTERN_PITCH_MIX_EN.
module block_pattern_gen #(
  parameter int          LANES     = 8,
  parameter int          MAX_HOT   = 2,
  parameter int          RETRY_MAX = 3,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             mode,
  input  logic [6:0]       addr,
  input  logic [6:0]       cur_tone,
  input  logic [2:0]       cur_pitch,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  output logic [LANES-1:0] v_enb,
  output logic             valid,
  output logic             busy
);
  localparam int  IW      = $clog2(LANES);
  localparam bit  IS_POW2 = (LANES & (LANES - 1)) == 0;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LANES-1:0] cand_q, cand_d;
  logic [LANES-1:0] prev_q, prev_d;
  logic [LANES-1:0] venb_q, venb_d;
  logic [2:0]       retry_q, retry_d;

  logic [15:0]      lfsr_cur, lfsr_step;
  logic [6:0]       addr_mod;
  logic [IW-1:0]    lane_idx;
  logic [LANES-1:0] pick, rot;
  int               hot_cnt;

  // A zero LFSR (from a load or a mix) is silently replaced by SEED before use.
  assign lfsr_cur  = (lfsr_q == 16'h0) ? SEED : lfsr_q;
  assign lfsr_step = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? 16'hB400 : 16'h0);

  generate
    if (IS_POW2) begin : g_pow2
      assign addr_mod = {{(7-IW){1'b0}}, addr[IW-1:0]};
    end else begin : g_mod
      assign addr_mod = addr % 7'(LANES);
    end
  endgenerate
  assign lane_idx = addr_mod[IW-1:0];

  // Keep only the lowest MAX_HOT set bits of the freshly stepped LFSR.
  always_comb begin
    pick    = '0;
    hot_cnt = 0;
    for (int i = 0; i < LANES; i++) begin
      if (lfsr_step[i] && hot_cnt < MAX_HOT) begin
        pick[i] = 1'b1;
        hot_cnt = hot_cnt + 1;
      end
    end
  end

  assign rot = (prev_q == '0) ? LANES'(1) : {prev_q[LANES-2:0], prev_q[LANES-1]};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_cur;
    cand_d  = cand_q;
    prev_d  = prev_q;
    venb_d  = venb_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) lfsr_d = seed_in;
        if (req) begin
          if (!mode) begin
            venb_d  = LANES'(1) << lane_idx;
            state_d = S_DONE;
          end else begin
            retry_d = 3'd0;
            state_d = S_GEN;
`ifdef BLOCK_PATTERN_PITCH_MIX_EN
            lfsr_d  = lfsr_d ^ {6'd0, cur_tone, cur_pitch};
`endif
          end
        end
      end
      S_GEN: begin
        lfsr_d  = lfsr_step;
        cand_d  = pick;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cand_q != '0 && cand_q != prev_q) begin
          venb_d  = cand_q;
          state_d = S_DONE;
        end else if (retry_q != 3'(RETRY_MAX)) begin
          retry_d = retry_q + 3'd1;
          state_d = S_GEN;
        end else begin
          venb_d  = rot;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        prev_d  = venb_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cand_q  <= '0;
      prev_q  <= '0;
      venb_q  <= '0;
      retry_q <= 3'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cand_q  <= cand_d;
      prev_q  <= prev_d;
      venb_q  <= venb_d;
      retry_q <= retry_d;
    end
  end

  assign v_enb = venb_q;
  assign valid = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);

  logic unused_ok;
  assign unused_ok = ^{addr_mod, lfsr_step, cur_tone, cur_pitch};
endmodule

// File: tb/tb_block_pattern_gen.sv
// Self-checking bench: table vectors, hand-written fallback/reset/seed sequences and
// randomized random-mode requests checked against a rule-level model.
module tb_block_pattern_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, mode, seed_load_a, seed_load_b;
  logic [6:0]  addr, cur_tone;
  logic [2:0]  cur_pitch;
  logic [15:0] seed_in;
  logic [7:0]  v_enb_a;
  logic [1:0]  v_enb_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int nv_a    = 0;
  int exp_nv_a = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (valid_a) nv_a++;

  block_pattern_gen #(.LANES(8), .MAX_HOT(2), .RETRY_MAX(3), .SEED(16'hACE1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .mode(mode), .addr(addr),
    .cur_tone(cur_tone), .cur_pitch(cur_pitch), .seed_load(seed_load_a), .seed_in(seed_in),
    .v_enb(v_enb_a), .valid(valid_a), .busy(busy_a));

  block_pattern_gen #(.LANES(2), .MAX_HOT(1), .RETRY_MAX(0), .SEED(16'hACE1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .mode(mode), .addr(addr),
    .cur_tone(cur_tone), .cur_pitch(cur_pitch), .seed_load(seed_load_b), .seed_in(seed_in),
    .v_enb(v_enb_b), .valid(valid_b), .busy(busy_b));

  // Reference state per instance: index 0 = u_a, 1 = u_b.
  int          P_LANES[2] = '{8, 2};
  int          P_HOT[2]   = '{2, 1};
  int          P_RMAX[2]  = '{3, 0};
  logic [15:0] m_lfsr[2];
  logic [7:0]  m_prev[2];
  logic [7:0]  last_v[2];

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] exp;
  } tvec_t;
  tvec_t tv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] out_v(input bit sel);
    return sel ? {6'd0, v_enb_b} : v_enb_a;
  endfunction
  function automatic logic out_valid(input bit sel);
    return sel ? valid_b : valid_a;
  endfunction
  function automatic logic out_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] lowest_bits(input logic [15:0] v, input int lanes, input int mh);
    logic [7:0] r;
    int c;
    r = '0;
    c = 0;
    for (int i = 0; i < lanes; i++)
      if (v[i] && c < mh) begin r[i] = 1'b1; c++; end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] p, input int lanes);
    logic [7:0] msk;
    msk = 8'((16'd1 << lanes) - 16'd1);
    if (p == 8'd0) return 8'd1;
    return ((p << 1) | (p >> (lanes - 1))) & msk;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_lfsr[s] = 16'hACE1;
      m_prev[s] = 8'd0;
      last_v[s] = 8'd0;
    end
  endtask

  task automatic set_req(input bit sel, input logic r, input logic sl);
    if (sel) begin req_b = r; seed_load_b = sl; end
    else     begin req_a = r; seed_load_a = sl; end
  endtask

  task automatic table_req(input bit sel, input logic [6:0] a, input logic [7:0] exp);
    addr = a;
    mode = 1'b0;
    set_req(sel, 1'b1, 1'b0);
    if (!sel) exp_nv_a++;
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0);
    check("tbl_valid", 32'(out_valid(sel)), 32'd1);
    check("tbl_busy", 32'(out_busy(sel)), 32'd1);
    check("tbl_venb", 32'(out_v(sel)), 32'(exp));
    @(posedge clk); #1;
    check("tbl_valid_drop", 32'(out_valid(sel)), 32'd0);
    check("tbl_hold", 32'(out_v(sel)), 32'(exp));
    m_prev[sel] = exp;
    last_v[sel] = exp;
  endtask

  // Issue one random-mode request and compare mask and latency with the model.
  // hold=1 keeps req and seed_load asserted for the whole busy period, DONE included.
  task automatic rand_req(input bit sel, input bit hold, input bit do_seed,
                          input logic [15:0] sd, input bit rnd_tp);
    logic [15:0] lf;
    logic [7:0]  c, expm;
    int          retries, exp_lat, n, nv;
    bit          found;
    cur_tone  = rnd_tp ? 7'($urandom) : 7'd0;
    cur_pitch = rnd_tp ? 3'($urandom) : 3'd0;
    seed_in   = sd;
    mode      = 1'b1;
    lf = do_seed ? sd : m_lfsr[sel];
`ifdef BLOCK_PATTERN_PITCH_MIX_EN
    lf = lf ^ {6'd0, cur_tone, cur_pitch};
`endif
    if (lf == 16'h0) lf = 16'hACE1;
    found = 1'b0;
    expm = 8'd0;
    retries = P_RMAX[sel];
    for (int r = 0; r <= P_RMAX[sel] && !found; r++) begin
      lf = lfsr_next(lf);
      c  = lowest_bits(lf, P_LANES[sel], P_HOT[sel]);
      if (c != 8'd0 && c != m_prev[sel]) begin
        found = 1'b1; expm = c; retries = r;
      end
    end
    if (!found) expm = rotl(m_prev[sel], P_LANES[sel]);
    exp_lat = 3 + 2 * retries;
    m_lfsr[sel] = lf;
    if (!sel) exp_nv_a++;

    set_req(sel, 1'b1, do_seed);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (hold) begin
        set_req(sel, 1'b1, 1'b1);
        seed_in = 16'($urandom);
      end else set_req(sel, 1'b0, 1'b0);
    end while (!out_valid(sel) && n < 40);
    check("rnd_latency", 32'(n), 32'(exp_lat));
    check("rnd_venb", 32'(out_v(sel)), 32'(expm));
    check("rnd_nonzero", 32'(out_v(sel) != 8'd0), 32'd1);
    check("rnd_popcnt_ok", 32'($countones(out_v(sel)) <= P_HOT[sel]), 32'd1);
    if (found) check("rnd_no_repeat", 32'(out_v(sel) != last_v[sel]), 32'd1);
    else check("fb_popcnt", 32'($countones(out_v(sel))),
               32'(last_v[sel] == 8'd0 ? 1 : $countones(last_v[sel])));
    last_v[sel] = out_v(sel);
    m_prev[sel] = expm;
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0);
    check("rnd_valid_pulse", 32'(out_valid(sel)), 32'd0);
    check("rnd_idle", 32'(out_busy(sel)), 32'd0);
    if (hold) begin
      nv = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (out_valid(sel) || out_busy(sel)) nv++;
      end
      check("hs_no_extra", 32'(nv), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; mode = 1'b0;
    seed_load_a = 1'b0; seed_load_b = 1'b0;
    addr = '0; cur_tone = '0; cur_pitch = '0; seed_in = '0;
    tv[0] = '{7'd13,  8'b0010_0000};
    tv[1] = '{7'd7,   8'b1000_0000};
    tv[2] = '{7'd0,   8'b0000_0001};
    tv[3] = '{7'd8,   8'b0000_0001};
    tv[4] = '{7'd127, 8'b1000_0000};
    tv[5] = '{7'd42,  8'b0000_0100};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_venb_a", 32'(v_enb_a), 32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_venb_b", 32'(v_enb_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) table_req(1'b0, tv[i].addr, tv[i].exp);

    // Random request aborted by reset while in GEN.
    mode = 1'b1;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    check("gen_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_venb", 32'(v_enb_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rand_req(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    rand_req(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    // Zero seed loaded together with req falls back to SEED.
    rand_req(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    rand_req(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    rand_req(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);

    // Requests and seed loads while busy, including DONE, are dropped.
    repeat (3) rand_req(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Small instance: forced fallbacks with prev=01 then prev=10.
    table_req(1'b1, 7'd4, 8'h01);
    rand_req(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0);
    check("fb_rot_01", 32'(v_enb_b), 32'd2);
    rand_req(1'b1, 1'b0, 1'b1, 16'h0008, 1'b0);
    check("fb_zero_cand", 32'(v_enb_b), 32'd1);
    for (int i = 0; i < 60; i++)
      rand_req(1'b1, 1'b0, (i % 7) == 0, 16'($urandom), 1'b1);

    for (int i = 0; i < 1000; i++)
      rand_req(1'b0, (i % 113) == 5, (i % 97) == 3, (i == 300) ? 16'h0 : 16'($urandom), 1'b1);

    check("valid_count", 32'(nv_a), 32'(exp_nv_a));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/block_pattern_gen.md
Name: block_pattern_gen

Overview:
- Sequential, parametrised lane-pattern generator for the falling-block display.
- On each note event it produces a lane-enable mask `v_enb` (one bit per lane) for the block renderer.
- Two modes:
  - Table mode: fixed mapping from the note address.
  - Random mode: LFSR-driven pattern with a hot-lane limit, no zero mask, and no consecutive-repeat rule.
- Sits between the score/note-address sequencer and the block renderer.

Parameters:
- LANES, 8: number of lanes / width of `v_enb`; legal 2..16.
- MAX_HOT, 2: maximum set bits per mask; legal 1..LANES.
- RETRY_MAX, 3: random-mode regeneration attempts before fallback; legal 0..7.
- SEED, 16'hACE1: LFSR reset/recovery value; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  note-event strobe; sampled only in IDLE.
- mode  in  1  0 = table mode, 1 = random mode; sampled with req.
- addr  in  7  current note address.
- cur_tone  in  7  current note tone index.
- cur_pitch  in  3  current octave/pitch class.
- seed_load  in  1  load `seed_in` into the LFSR; honoured in IDLE only.
- seed_in  in  16  LFSR load value.
- v_enb  out  LANES  registered lane mask; holds until the next result.
- valid  out  1  one-cycle pulse when `v_enb` has just updated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, v_enb=0, prev=0, valid=0, busy=0, retry=0, lfsr=SEED.
  - Reset mid-operation aborts immediately to these values; no partial mask is output.
- LFSR: 16-bit Galois, polynomial 0xB400, shifts right. Advances only in GEN, one step per GEN cycle. If it ever holds 0 (load or mix), it is replaced by SEED on the next clock.
- FSM states: IDLE, GEN, CHECK, DONE.
- IDLE:
  - seed_load=1: lfsr <= seed_in. req in the same cycle is still accepted; GEN then steps from the loaded value.
  - req=1, mode=0: v_enb <= 1 << (addr % LANES); go to DONE. Table-mode latency is 1 cycle (valid in the cycle after req).
  - req=1, mode=1: retry <= 0; go to GEN.
  - req outside IDLE: ignored, not queued. seed_load outside IDLE: ignored.
- GEN:
  - Step the LFSR.
  - cand <= lowest MAX_HOT set bits of lfsr_next[LANES-1:0]; higher set bits are cleared.
  - Go to CHECK.
- CHECK:
  - Reject if cand==0 or cand==prev.
  - Accept: v_enb <= cand; go to DONE.
  - Reject with retry<RETRY_MAX: retry++; go to GEN.
  - Reject with retry==RETRY_MAX: fallback. v_enb <= prev rotated left by 1 within LANES, or 1 if prev==0. Go to DONE.
- DONE: valid=1 for exactly this cycle; prev <= v_enb; go to IDLE.
- Random-mode latency: 3 + 2*retries cycles from req to valid; worst case 3 + 2*RETRY_MAX.
- Invariants, both modes:
  - v_enb is non-zero after the first valid.
  - popcount(v_enb) ≤ MAX_HOT; a fallback mask has the same popcount as prev.
  - Random mode never repeats prev.
- Table mode updates prev, but is not itself subject to the repeat check.
- addr % LANES is a bit slice when LANES is a power of 2, otherwise a combinational modulo. Width is $clog2(LANES).

Optional Feature:
- Macro: BLOCK_PATTERN_PITCH_MIX_EN.
- Defined: on req accepted in IDLE with mode=1, lfsr[9:0] ^= {cur_tone, cur_pitch}. This is applied after any same-cycle seed_load. If the result is 0, the zero-recovery rule applies before GEN.
- Undefined: cur_tone and cur_pitch are unused; the LFSR depends only on SEED, seed_load and step count.

Test Plan:
- Reset: drive rst_n=0 mid-GEN -> v_enb=0, valid=0, busy=0 asynchronously; after release, first random req with no seed load matches the reference model started from 16'hACE1.
- Table mode, LANES=8:
  - addr=13, req -> v_enb=8'b0010_0000, valid high in the next cycle, busy high for 1 cycle.
  - addr=7 -> 8'b1000_0000.
- Random mode, 1000 back-to-back reqs (each req issued on the first IDLE cycle after valid) -> every v_enb non-zero, popcount≤2, v_enb≠previous; valid count = 1000.
- Fallback, LANES=2, MAX_HOT=1, RETRY_MAX=0: when the candidate equals prev (e.g. prev=2'b01) -> v_enb=2'b10, delivered 3 cycles after req.
- Seed and zero recovery: seed_load=1, seed_in=0, with req in the same cycle -> LFSR forced to 16'hACE1; output matches the post-reset sequence.
- Handshake: req pulsed while busy=1 -> no extra valid; mode=1 req during DONE ignored; exactly one valid per accepted req.
